// File: rtl/t_ff_bank_counter.sv
// Bank of WIDTH toggle cells: per-bit toggle, up/down count, or parallel load.
// Every update is expressed as a toggle mask applied to the register.
module t_ff_bank_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  mode_e            w_mode;
  logic [WIDTH-1:0] w_up_tog;
  logic [WIDTH-1:0] w_dn_tog;
  logic [WIDTH-1:0] w_tog;
  logic             w_all_ones;
  logic             w_all_zero;
  logic             w_ovf_nxt;

  assign w_mode     = mode_e'(mode);
  assign w_all_ones = &r_q;
  assign w_all_zero = ~|r_q;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
  always_comb begin
    logic v_ones;
    logic v_zero;
    w_up_tog = '0;
    w_dn_tog = '0;
    v_ones   = 1'b1;
    v_zero   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_up_tog[i] = v_ones;
      w_dn_tog[i] = v_zero;
      v_ones      = v_ones & r_q[i];
      v_zero      = v_zero & ~r_q[i];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_tog     = '0;
    w_ovf_nxt = 1'b0;
    if (en) begin
      unique case (w_mode)
        MODE_TOGGLE: w_tog = t;
        MODE_UP: begin
          w_ovf_nxt = w_all_ones;
          w_tog     = (SATURATE && w_all_ones) ? '0 : w_up_tog;
        end
        MODE_DOWN: begin
          w_ovf_nxt = w_all_zero;
          w_tog     = (SATURATE && w_all_zero) ? '0 : w_dn_tog;
        end
        MODE_LOAD: w_tog = r_q ^ d;
        default:   w_tog = '0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q   <= RESET_VAL;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= r_q ^ w_tog;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign q   = r_q;
  assign qb  = ~r_q;
  assign ovf = r_ovf;

endmodule

// File: doc/t_ff_bank_counter.md
Name: t_ff_bank_counter

Overview:
- Parametrised successor of the single-bit toggle flip-flop: a WIDTH-bit register built from toggle (T) cells.
- Four run-time modes: independent per-bit toggle, synchronous up count, synchronous down count, parallel load.
- Provides true and complement outputs, like the single-bit cell, plus a registered overflow flag.
- Used as a general toggle bank or as an event/timer counter.

Parameters:
WIDTH, 4, number of T cells (register width), minimum 1
RESET_VAL, 0, value loaded into q on reset, WIDTH bits
SATURATE, 0, 0 = counters wrap at the limits, 1 = counters stick at the limits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset, sampled on rising clk
en  input  1  step enable; when low the register holds
mode  input  2  00 toggle, 01 count up, 10 count down, 11 load
t  input  WIDTH  per-bit toggle mask, used in mode 00
d  input  WIDTH  parallel load data, used in mode 11
q  output  WIDTH  register state
qb  output  WIDTH  bitwise complement of q, always equal to ~q
ovf  output  1  registered wrap or saturation indication

Behaviour:
- All state updates occur on the rising clk edge; no asynchronous paths.
- Reset:
  - rst low at the edge -> q = RESET_VAL, qb = ~RESET_VAL, ovf = 0.
  - Reset has priority over en and mode.
  - Reset asserted mid-count aborts the count on that edge.
- en low (rst high): q holds and ovf is cleared to 0 on the edge.
- en high, mode 00 (toggle):
  - q <= q ^ t, so each bit behaves as an independent T flip-flop.
  - t = 0 holds q.
  - ovf <= 0.
- en high, mode 01 (up), q != all-ones: q <= q + 1, ovf <= 0.
- en high, mode 01 (up), q == all-ones:
  - SATURATE = 0: q <= 0, ovf <= 1.
  - SATURATE = 1: q holds all-ones, ovf <= 1.
- en high, mode 10 (down), q != 0: q <= q - 1, ovf <= 0.
- en high, mode 10 (down), q == 0:
  - SATURATE = 0: q <= all-ones, ovf <= 1.
  - SATURATE = 1: q holds 0, ovf <= 1.
- en high, mode 11 (load): q <= d, ovf <= 0. Load has no limit check.
- Counting is implemented as toggle logic:
  - Up: bit i toggles when en is high and all lower bits of q are 1.
  - Down: bit i toggles when en is high and all lower bits of q are 0.
  - Bit 0 always toggles when counting.
  - The saturation hold overrides the toggle enables.
- ovf timing:
  - One-cycle latency; ovf is high in the same cycle q first shows the wrapped (or held) value.
  - Continuous stepping at a saturated limit keeps ovf high every cycle.
  - Any non-limit step, any load, or en low drops ovf on the next edge.
- Mode change takes effect on the edge where it is sampled; there are no pipeline bubbles.
- qb is combinational ~q and is never out of step with q.
- WIDTH = 1:
  - Mode 00 is the classic T flip-flop.
  - Up and down counting both toggle q, and both flag ovf on the wrap.

Test Plan:
- Reset (WIDTH=4, RESET_VAL=4'h5): drive rst=0 for one edge with en=1, mode=01 -> q=5, qb=A, ovf=0. Release rst, hold en=0 for 3 cycles -> q stays 5.
- Toggle mode: from q=0, mode=00, apply t=1,3,3,0,F on successive edges -> q=1,2,1,1,E; qb tracks ~q each cycle; ovf stays 0.
- Up wrap (SATURATE=0): load d=E, then count up for 3 edges -> q=F,0,1; ovf=0,1,0.
- Down saturate (SATURATE=1): load d=1, then count down for 4 edges -> q=0,0,0,0; ovf=0,1,1,1. Then switch to count up -> q=1, ovf=0.
- Reset mid-operation: counting up at q=9, drive rst=0 on the next edge with en=1 -> q=RESET_VAL and ovf=0. Counting resumes from RESET_VAL one edge after rst returns high.
- Enable gating: counting up with q=7 and en toggling 1,0,1,0 -> q=8,8,9,9. With q=F, wrap on an en=1 edge gives ovf=1, and the following en=0 edge gives ovf=0.
